// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, control encodings and the ALU decoder.
package riscv_pkg;

   localparam int REG_ADDR_W = 5;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } alu_ctrl_e;

   typedef enum logic [1:0] {
      IMM_I = 2'b00,
      IMM_S = 2'b01,
      IMM_B = 2'b10,
      IMM_J = 2'b11
   } imm_src_e;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10
   } result_src_e;

   typedef struct packed {
      logic        reg_write;
      logic        mem_write;
      logic        jump;
      logic        branch;
      logic        alu_src;
      result_src_e result_src;
      alu_ctrl_e   alu_ctrl;
   } ctrl_t;

   // Unsupported funct3 values fall back to add.
   function automatic alu_ctrl_e alu_decode(input logic [2:0] funct3, input logic is_sub);
      case (funct3)
         3'b000:  return is_sub ? ALU_SUB : ALU_ADD;
         3'b010:  return ALU_SLT;
         3'b110:  return ALU_OR;
         3'b111:  return ALU_AND;
         default: return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/reg_file.sv
// 2R1W register file with x0 hardwired to zero, async clear and write-through bypass.
module reg_file
   import riscv_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int REG_COUNT  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] rs1,
   input  logic [REG_ADDR_W-1:0] rs2,
   output logic [DATA_WIDTH-1:0] rd1,
   output logic [DATA_WIDTH-1:0] rd2,
   input  logic                  we,
   input  logic [REG_ADDR_W-1:0] rd,
   input  logic [DATA_WIDTH-1:0] wd
);

   logic [DATA_WIDTH-1:0] regs [REG_COUNT];

   // NOTE: the array is cleared by reset, which forces it into flops rather than a RAM macro.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      end else if (we && rd != '0) begin
         regs[rd] <= wd;
      end
   end

   // A write landing this cycle is visible to the reader, so ID/EX captures the new value.
   always_comb begin
      if (rs1 == '0)                  rd1 = '0;
      else if (we && rd == rs1)       rd1 = wd;
      else                            rd1 = regs[rs1];
      if (rs2 == '0)                  rd2 = '0;
      else if (we && rd == rs2)       rd2 = wd;
      else                            rd2 = regs[rs2];
   end

endmodule

// File: rtl/decode_stage.sv
// RV32I ID stage: control decode, immediate generation, regfile read and ID/EX register.
// Optional illegal-instruction flagging is enabled by defining DECODE_ILLEGAL_DETECT_EN.
module decode_stage
   import riscv_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int REG_COUNT  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [31:0]           InsD,
   input  logic [ADDR_WIDTH-1:0] PC_D,
   input  logic [ADDR_WIDTH-1:0] PC_4D,
   input  logic                  RegWriteW,
   input  logic [REG_ADDR_W-1:0] RdW,
   input  logic [DATA_WIDTH-1:0] ResultW,
   input  logic                  FlushE,
   output logic [REG_ADDR_W-1:0] Rs1D,
   output logic [REG_ADDR_W-1:0] Rs2D,
   output logic                  RegWriteE,
   output logic                  MemWriteE,
   output logic                  JumpE,
   output logic                  BranchE,
   output logic                  ALUSrcE,
   output logic [1:0]            ResultSrcE,
   output logic [2:0]            ALUControlE,
   output logic [DATA_WIDTH-1:0] RD1E,
   output logic [DATA_WIDTH-1:0] RD2E,
   output logic [DATA_WIDTH-1:0] ImmExtE,
   output logic [REG_ADDR_W-1:0] Rs1E,
   output logic [REG_ADDR_W-1:0] Rs2E,
   output logic [REG_ADDR_W-1:0] RdE,
   output logic [ADDR_WIDTH-1:0] PCE,
   output logic [ADDR_WIDTH-1:0] PC_4E,
   output logic                  IllegalE
);

   logic [6:0]            opcode;
   logic [2:0]            funct3;
   ctrl_t                 ctrl;
   imm_src_e              imm_src;
   logic                  has_imm;
   logic                  illegal;
   logic [DATA_WIDTH-1:0] imm_ext;
   logic [DATA_WIDTH-1:0] rd1, rd2;

   assign opcode = InsD[6:0];
   assign funct3 = InsD[14:12];
   assign Rs1D   = InsD[19:15];
   assign Rs2D   = InsD[24:20];

   reg_file #(.DATA_WIDTH(DATA_WIDTH), .REG_COUNT(REG_COUNT)) u_reg_file (
      .clk   (clk),
      .rst_n (rst_n),
      .rs1   (Rs1D),
      .rs2   (Rs2D),
      .rd1   (rd1),
      .rd2   (rd2),
      .we    (RegWriteW),
      .rd    (RdW),
      .wd    (ResultW)
   );

   // NOTE: every signal gets a default first so no path through the case infers a latch.
   always_comb begin
      ctrl    = '0;
      imm_src = IMM_I;
      has_imm = 1'b0;
      illegal = 1'b0;
      case (opcode)
         OP_LW: begin
            ctrl.reg_write  = 1'b1;
            ctrl.alu_src    = 1'b1;
            ctrl.result_src = RES_MEM;
            has_imm         = 1'b1;
         end
         OP_SW: begin
            ctrl.mem_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            imm_src        = IMM_S;
            has_imm        = 1'b1;
         end
         OP_R: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_ctrl  = alu_decode(funct3, InsD[30]);
         end
         OP_I: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_ctrl  = alu_decode(funct3, 1'b0);
            has_imm        = 1'b1;
         end
         OP_BEQ: begin
            ctrl.branch   = 1'b1;
            ctrl.alu_ctrl = ALU_SUB;
            imm_src       = IMM_B;
            has_imm       = 1'b1;
         end
         OP_JAL: begin
            ctrl.reg_write  = 1'b1;
            ctrl.jump       = 1'b1;
            ctrl.result_src = RES_PC4;
            imm_src         = IMM_J;
            has_imm         = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
`ifdef DECODE_ILLEGAL_DETECT_EN
      if ((opcode == OP_R || opcode == OP_I) &&
          !(funct3 inside {3'b000, 3'b010, 3'b110, 3'b111}))
         illegal = 1'b1;
      if (opcode == OP_R && !(InsD[31:25] inside {7'b0000000, 7'b0100000}))
         illegal = 1'b1;
      if (illegal) ctrl = '0;
`endif
   end

   always_comb begin
      imm_ext = '0;
      if (has_imm) begin
         case (imm_src)
            IMM_I: imm_ext = {{(DATA_WIDTH-12){InsD[31]}}, InsD[31:20]};
            IMM_S: imm_ext = {{(DATA_WIDTH-12){InsD[31]}}, InsD[31:25], InsD[11:7]};
            IMM_B: imm_ext = {{(DATA_WIDTH-13){InsD[31]}}, InsD[31], InsD[7],
                              InsD[30:25], InsD[11:8], 1'b0};
            IMM_J: imm_ext = {{(DATA_WIDTH-21){InsD[31]}}, InsD[31], InsD[19:12],
                              InsD[20], InsD[30:21], 1'b0};
            default: imm_ext = '0;
         endcase
      end
   end

   // NOTE: pipeline state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || FlushE) begin
         if (!rst_n || FlushE) begin
            RegWriteE   <= 1'b0;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUSrcE     <= 1'b0;
            ResultSrcE  <= '0;
            ALUControlE <= '0;
            RD1E        <= '0;
            RD2E        <= '0;
            ImmExtE     <= '0;
            Rs1E        <= '0;
            Rs2E        <= '0;
            RdE         <= '0;
            PCE         <= '0;
            PC_4E       <= '0;
         end
      end else begin
         RegWriteE   <= ctrl.reg_write;
         MemWriteE   <= ctrl.mem_write;
         JumpE       <= ctrl.jump;
         BranchE     <= ctrl.branch;
         ALUSrcE     <= ctrl.alu_src;
         ResultSrcE  <= ctrl.result_src;
         ALUControlE <= ctrl.alu_ctrl;
         RD1E        <= rd1;
         RD2E        <= rd2;
         ImmExtE     <= imm_ext;
         Rs1E        <= Rs1D;
         Rs2E        <= Rs2D;
         RdE         <= InsD[11:7];
         PCE         <= PC_D;
         PC_4E       <= PC_4D;
      end
   end

`ifdef DECODE_ILLEGAL_DETECT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      IllegalE <= 1'b0;
      else if (FlushE) IllegalE <= 1'b0;
      else             IllegalE <= illegal;
   end
`else
   logic unused_illegal;
   assign unused_illegal = illegal;
   assign IllegalE       = 1'b0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Randomized self-checking bench for decode_stage against a behavioural ID-stage model.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] InsD, PC_D, PC_4D, ResultW;
   logic        RegWriteW, FlushE;
   logic [4:0]  RdW, Rs1D, Rs2D, Rs1E, Rs2E, RdE;
   logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, IllegalE;
   logic [1:0]  ResultSrcE;
   logic [2:0]  ALUControlE;
   logic [31:0] RD1E, RD2E, ImmExtE, PCE, PC_4E;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] regs [32];

   typedef struct {
      logic        rw, mw, jp, br, as, ill, imm_dc;
      logic [1:0]  rsrc;
      logic [2:0]  alu;
      logic [31:0] imm, rd1, rd2, pc, pc4;
      logic [4:0]  r1, r2, rd;
   } exp_t;

   decode_stage dut (
      .clk(clk), .rst_n(rst_n), .InsD(InsD), .PC_D(PC_D), .PC_4D(PC_4D),
      .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .FlushE(FlushE),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
      .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
      .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
      .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .PCE(PCE), .PC_4E(PC_4E), .IllegalE(IllegalE)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rf_read(input logic [4:0] a, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
      if (a == 0) return 0;
      if (we && wa == a) return wd;
      return regs[a];
   endfunction

   function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic we, input logic [4:0] wa,
                                      input logic [31:0] wd, input logic flush);
      exp_t        e;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [2:0]  alu_r;
      logic [11:0] i12, s12;
      logic [12:0] b13;
      logic [20:0] j21;
      logic        known;
      e = '{default: '0};
      if (flush) return e;
      op  = ins[6:0];
      f3  = ins[14:12];
      f7  = ins[31:25];
      e.r1  = ins[19:15];
      e.r2  = ins[24:20];
      e.rd  = ins[11:7];
      e.pc  = pc;
      e.pc4 = pc + 4;
      e.rd1 = rf_read(e.r1, we, wa, wd);
      e.rd2 = rf_read(e.r2, we, wa, wd);
      if (f3 == 0)      alu_r = (op == 7'h33 && f7[5]) ? 3'd1 : 3'd0;
      else if (f3 == 2) alu_r = 3'd5;
      else if (f3 == 6) alu_r = 3'd3;
      else if (f3 == 7) alu_r = 3'd2;
      else              alu_r = 3'd0;
      i12 = ins[31:20];
      s12 = {ins[31:25], ins[11:7]};
      b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      known = 1'b1;
      case (op)
         7'h03: begin e.rw = 1; e.as = 1; e.rsrc = 1; e.imm = 32'($signed(i12)); end
         7'h23: begin e.mw = 1; e.as = 1; e.imm = 32'($signed(s12)); end
         7'h33: begin e.rw = 1; e.alu = alu_r; e.imm = 0; end
         7'h13: begin e.rw = 1; e.as = 1; e.alu = alu_r; e.imm = 32'($signed(i12)); end
         7'h63: begin e.br = 1; e.alu = 1; e.imm = 32'($signed(b13)); end
         7'h6F: begin e.rw = 1; e.jp = 1; e.rsrc = 2; e.imm = 32'($signed(j21)); end
         default: begin known = 0; e.imm_dc = 1; end
      endcase
`ifdef DECODE_ILLEGAL_DETECT_EN
      e.ill = !known ||
              ((op == 7'h33 || op == 7'h13) && !(f3 == 0 || f3 == 2 || f3 == 6 || f3 == 7)) ||
              (op == 7'h33 && f7 != 0 && f7 != 7'h20);
      if (e.ill) begin
         e.rw = 0; e.mw = 0; e.jp = 0; e.br = 0; e.as = 0; e.rsrc = 0; e.alu = 0;
         e.imm_dc = 1;
      end
`endif
      return e;
   endfunction

   task automatic check_all(input exp_t e);
      check("RegWriteE",   32'(RegWriteE),   32'(e.rw));
      check("MemWriteE",   32'(MemWriteE),   32'(e.mw));
      check("JumpE",       32'(JumpE),       32'(e.jp));
      check("BranchE",     32'(BranchE),     32'(e.br));
      check("ALUSrcE",     32'(ALUSrcE),     32'(e.as));
      check("ResultSrcE",  32'(ResultSrcE),  32'(e.rsrc));
      check("ALUControlE", 32'(ALUControlE), 32'(e.alu));
      if (!e.imm_dc) check("ImmExtE", ImmExtE, e.imm);
      check("RD1E",        RD1E,             e.rd1);
      check("RD2E",        RD2E,             e.rd2);
      check("Rs1E",        32'(Rs1E),        32'(e.r1));
      check("Rs2E",        32'(Rs2E),        32'(e.r2));
      check("RdE",         32'(RdE),         32'(e.rd));
      check("PCE",         PCE,              e.pc);
      check("PC_4E",       PC_4E,            e.pc4);
      check("IllegalE",    32'(IllegalE),    32'(e.ill));
   endtask

   // Drive one ID-stage cycle, then compare ID/EX one edge later.
   task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd, input logic flush);
      exp_t e;
      InsD = ins; PC_D = pc; PC_4D = pc + 4;
      RegWriteW = we; RdW = wa; ResultW = wd; FlushE = flush;
      #1;
      check("Rs1D", 32'(Rs1D), 32'(ins[19:15]));
      check("Rs2D", 32'(Rs2D), 32'(ins[24:20]));
      e = ref_model(ins, pc, we, wa, wd, flush);
      @(posedge clk);
      if (we && wa != 0) regs[wa] = wd;
      #1;
      check_all(e);
   endtask

   function automatic logic [31:0] rand_ins();
      logic [31:0] ins;
      logic [6:0]  ops [6];
      ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F};
      ins = $urandom;
      if ($urandom_range(7) != 0) ins[6:0] = ops[$urandom_range(5)];
      if (ins[6:0] == 7'h33 && $urandom_range(3) != 0)
         ins[31:25] = $urandom_range(1) ? 7'h20 : 7'h00;
      return ins;
   endfunction

   task automatic rand_phase(input int n);
      for (int k = 0; k < n; k++)
         step(rand_ins(), {$urandom_range(32'h3FFF_FFFF), 2'b00}, 1'($urandom_range(1)),
              5'($urandom_range(31)), $urandom, $urandom_range(7) == 0);
   endtask

   task automatic check_reset_zero();
      exp_t z;
      z = '{default: '0};
      check_all(z);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = 0;
      rst_n = 1'b0;
      InsD = 32'h00500093; PC_D = 32'h40; PC_4D = 32'h44;
      RegWriteW = 0; RdW = 0; ResultW = 0; FlushE = 0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_zero();
      rst_n = 1'b1;

      // Read of x5 straight after reset.
      step(32'h00028093, 32'h100, 0, 0, 0, 0);
      check("x5_after_reset", RD1E, 32'h0);
      // addi x1,x0,5
      step(32'h00500093, 32'h104, 0, 0, 0, 0);
      check("addi_imm", ImmExtE, 32'h5);
      check("addi_rd",  32'(RdE), 32'h1);
      // Same-cycle writeback bypass into add x3,x2,x2
      step(32'h002101B3, 32'h108, 1, 2, 32'hDEADBEEF, 0);
      check("bypass_rd1", RD1E, 32'hDEADBEEF);
      check("bypass_rd2", RD2E, 32'hDEADBEEF);
      // x0 write is dropped
      step(32'h00000013, 32'h10C, 1, 0, 32'h1234, 0);
      step(32'h000000B3, 32'h110, 0, 0, 0, 0);
      check("x0_rd1", RD1E, 32'h0);
      // Flush bubble, then the same sw unflushed
      step(32'h0020A223, 32'h114, 0, 0, 0, 1);
      check("flush_pc", PCE, 32'h0);
      step(32'h0020A223, 32'h114, 0, 0, 0, 0);
      check("sw_mw",  32'(MemWriteE), 32'h1);
      check("sw_imm", ImmExtE, 32'h4);
      // beq x0,x0,-4
      step(32'hFE000EE3, 32'h118, 0, 0, 0, 0);
      check("beq_imm", ImmExtE, 32'hFFFFFFFC);
      // Unlisted opcode
      step(32'h0000007F, 32'h11C, 0, 0, 0, 0);

      rand_phase(400);

      // Asynchronous reset mid-cycle clears ID/EX and the register file.
      #3 rst_n = 1'b0;
      #1;
      check_reset_zero();
      for (int i = 0; i < 32; i++) regs[i] = 0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      step(32'h00028093, 32'h200, 0, 0, 0, 0);
      check("x5_after_midreset", RD1E, 32'h0);

      rand_phase(400);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
